// File: rtl/stream_beat_accumulator_pkg.sv
// Shared types and width helpers for the stream beat accumulator.
package stream_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } acc_state_e;

    // Sum width must hold BEATS full-scale beats; a single-beat frame still gets one carry bit.
    function automatic int sum_width(input int width, input int beats);
        int w;
        w = width + $clog2(beats);
        if (w < width + 1) w = width + 1;
        return w;
    endfunction

    function automatic int cnt_width(input int beats);
        return $clog2(beats + 1);
    endfunction

endpackage

// File: rtl/stream_beat_accumulator_if.sv
// Beat input stream and frame-result output stream of the accumulator.
// Valid/ready: a transfer happens on a rising clk edge where valid && ready; payload is held stable while valid waits for ready.
interface stream_beat_accumulator_if
    import stream_acc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BEATS = 4
);
    localparam int SUM_W = sum_width(WIDTH, BEATS);
    localparam int CNT_W = cnt_width(BEATS);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_data;
    logic [CNT_W-1:0] out_beats;
    acc_state_e       state;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_beats, state
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_beats, state
    );

endinterface

// File: rtl/stream_beat_accumulator.sv
// Sums up to BEATS input beats per frame (early close on in_last) and presents
// the frame sum and beat count on a registered valid/ready output.
module stream_beat_accumulator
    import stream_acc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BEATS = 4
) (
    input logic                      clk,
    input logic                      resetn,
    stream_beat_accumulator_if.slave bus
);
    localparam int SUM_W = sum_width(WIDTH, BEATS);
    localparam int CNT_W = cnt_width(BEATS);

    acc_state_e       state_q, state_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_beats_q, out_beats_d;
    logic [SUM_W-1:0] beat_ext;
    logic             accept;
    logic             frame_end;

    // in_ready looks only at state and out_ready, never at in_valid.
    assign bus.in_ready  = !resetn && (state_q == ACCUM || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign beat_ext      = SUM_W'(bus.in_data);
    assign frame_end     = bus.in_last || (cnt_q == CNT_W'(BEATS - 1));

    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_data  = out_data_q;
    assign bus.out_beats = out_beats_q;
    assign bus.state     = state_q;

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_beats_d = out_beats_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (frame_end) begin
                        out_data_d  = sum_q + beat_ext;
                        out_beats_d = cnt_q + CNT_W'(1);
                        sum_d       = '0;
                        cnt_d       = '0;
                        state_d     = EMIT;
                    end else begin
                        sum_d = sum_q + beat_ext;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    // A beat taken while the result drains opens the next frame in the same cycle.
                    if (accept && (BEATS == 1 || bus.in_last)) begin
                        out_data_d  = beat_ext;
                        out_beats_d = CNT_W'(1);
                        sum_d       = '0;
                        cnt_d       = '0;
                    end else if (accept) begin
                        sum_d   = beat_ext;
                        cnt_d   = CNT_W'(1);
                        state_d = ACCUM;
                    end else begin
                        sum_d   = '0;
                        cnt_d   = '0;
                        state_d = ACCUM;
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q     <= ACCUM;
            sum_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_beats_q <= '0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_beats_q <= out_beats_d;
        end
    end

endmodule

// File: tb/tb_stream_beat_accumulator.sv
// Bench for stream_beat_accumulator: directed scenarios plus a randomized
// stream, scored against a frame-level sum model.
module tb_stream_beat_accumulator;
    localparam int WIDTH = 32;
    localparam int BEATS = 4;
    localparam int SUM_W = WIDTH + $clog2(BEATS);
    localparam int CNT_W = $clog2(BEATS + 1);

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    stream_beat_accumulator_if #(.WIDTH(WIDTH), .BEATS(BEATS)) bus ();

    stream_beat_accumulator #(.WIDTH(WIDTH), .BEATS(BEATS)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int passed = 0;
    bit rand_ready = 1'b0;

    logic [SUM_W-1:0] exp_q[$];
    logic [CNT_W-1:0] expb_q[$];
    logic [SUM_W-1:0] obs_q[$];
    logic [CNT_W-1:0] obsb_q[$];
    longint m_sum = 0;
    int     m_cnt = 0;

    // Reference model: frame sum and count from the stream of accepted beats.
    initial forever begin
        @(negedge clk);
        #2;
        if (resetn) begin
            m_sum = 0;
            m_cnt = 0;
            exp_q.delete();
            expb_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                obs_q.push_back(bus.out_data);
                obsb_q.push_back(bus.out_beats);
            end
            if (bus.in_valid && bus.in_ready) begin
                m_sum = m_sum + longint'(bus.in_data);
                m_cnt = m_cnt + 1;
                if (bus.in_last || m_cnt == BEATS) begin
                    exp_q.push_back(SUM_W'(m_sum));
                    expb_q.push_back(CNT_W'(m_cnt));
                    m_sum = 0;
                    m_cnt = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end

    // Call at a negedge; returns at the negedge after the beat is accepted.
    task automatic drive_beat(input logic [WIDTH-1:0] d, input logic l, output int waits);
        waits = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        forever begin
            #1;
            if (bus.in_ready) begin
                @(negedge clk);
                break;
            end
            @(negedge clk);
            waits++;
            if (waits >= 200) begin
                checks++;
                $display("FAIL beat_accept_timeout: data %h not accepted in %0d cycles", d, waits);
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic pop_result(output logic [SUM_W-1:0] s, output logic [CNT_W-1:0] b, output bit ok);
        ok = 1'b0;
        s  = '0;
        b  = '0;
        for (int i = 0; i < 200; i++) begin
            if (obs_q.size() > 0) begin
                s  = obs_q.pop_front();
                b  = obsb_q.pop_front();
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pop_exp(output logic [SUM_W-1:0] s, output logic [CNT_W-1:0] b);
        s = 'x;
        b = 'x;
        if (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            b = expb_q.pop_front();
        end
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
        checks++;
        if (bus.out_data !== '0) $display("FAIL reset_out_data: got %h want 0", bus.out_data); else passed++;
        checks++;
        if (bus.out_beats !== '0) $display("FAIL reset_out_beats: got %0d want 0", bus.out_beats); else passed++;
        checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else passed++;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", bus.in_ready); else passed++;
        @(negedge clk);
    endtask

    task automatic test_full_frame();
        int w;
        logic [SUM_W-1:0] s, es;
        logic [CNT_W-1:0] b, eb;
        bit ok;
        bus.out_ready = 1'b1;
        drive_beat(32'd1, 1'b0, w);
        drive_beat(32'd2, 1'b0, w);
        drive_beat(32'd3, 1'b0, w);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL full_early_valid: got %b want 0", bus.out_valid); else passed++;
        @(negedge clk);
        drive_beat(32'd4, 1'b0, w);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== SUM_W'(10) || bus.out_beats !== CNT_W'(4))
            $display("FAIL full_result: got v=%b d=%0d n=%0d want v=1 d=10 n=4", bus.out_valid, bus.out_data, bus.out_beats);
        else passed++;
        pop_result(s, b, ok);
        pop_exp(es, eb);
        checks++;
        if (!ok || s !== es || b !== eb) $display("FAIL full_scoreboard: got %h/%0d want %h/%0d", s, b, es, eb); else passed++;
        @(negedge clk);
    endtask

    task automatic test_early_end();
        int w;
        logic [SUM_W-1:0] s, es;
        logic [CNT_W-1:0] b, eb;
        bit ok;
        bus.out_ready = 1'b1;
        drive_beat(32'hFFFF_FFFF, 1'b0, w);
        drive_beat(32'h1, 1'b1, w);
        pop_result(s, b, ok);
        pop_exp(es, eb);
        checks++;
        if (!ok || s !== 34'h1_0000_0000 || b !== CNT_W'(2) || s !== es || b !== eb)
            $display("FAIL early_end: got %h/%0d want 100000000/2 (model %h/%0d)", s, b, es, eb);
        else passed++;
        // in_last on the fourth beat closes one frame of four, not more.
        for (int i = 0; i < BEATS; i++) drive_beat(32'd100 + 32'(i), (i == BEATS - 1), w);
        drive_beat(32'd7, 1'b1, w);
        pop_result(s, b, ok);
        pop_exp(es, eb);
        checks++;
        if (!ok || s !== SUM_W'(406) || b !== CNT_W'(4) || s !== es || b !== eb)
            $display("FAIL last_on_full: got %0d/%0d want 406/4", s, b);
        else passed++;
        pop_result(s, b, ok);
        pop_exp(es, eb);
        checks++;
        if (!ok || s !== SUM_W'(7) || b !== CNT_W'(1) || s !== es || b !== eb)
            $display("FAIL after_last_on_full: got %0d/%0d want 7/1", s, b);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int w;
        logic [SUM_W-1:0] s, es;
        logic [CNT_W-1:0] b, eb;
        bit ok;
        bus.out_ready = 1'b0;
        for (int i = 0; i < BEATS; i++) drive_beat(WIDTH'($urandom), 1'b0, w);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd7;
        bus.in_last  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || exp_q.size() == 0 ||
                bus.out_data !== exp_q[0] || bus.out_beats !== expb_q[0])
                $display("FAIL bp_hold_%0d: got rdy=%b v=%b d=%h n=%0d", c, bus.in_ready, bus.out_valid, bus.out_data, bus.out_beats);
            else passed++;
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); else passed++;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < BEATS - 1; i++) drive_beat(32'd1, 1'b0, w);
        for (int r = 0; r < 2; r++) begin
            pop_result(s, b, ok);
            pop_exp(es, eb);
            checks++;
            if (!ok || s !== es || b !== eb) $display("FAIL bp_result_%0d: got %h/%0d want %h/%0d", r, s, b, es, eb); else passed++;
        end
        checks++;
        if (eb !== CNT_W'(4) || es !== SUM_W'(10)) $display("FAIL bp_second_frame: got %0d/%0d want 10/4", es, eb); else passed++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int w, total_waits;
        logic [SUM_W-1:0] s, es;
        logic [CNT_W-1:0] b, eb;
        bit ok;
        bus.out_ready = 1'b1;
        total_waits = 0;
        for (int i = 0; i < 3 * BEATS; i++) begin
            drive_beat(32'h10, 1'b0, w);
            total_waits += w;
        end
        checks++;
        if (total_waits != 0) $display("FAIL seamless_stalls: got %0d stall cycles want 0", total_waits); else passed++;
        for (int r = 0; r < 3; r++) begin
            pop_result(s, b, ok);
            pop_exp(es, eb);
            checks++;
            if (!ok || s !== SUM_W'(64) || b !== CNT_W'(4) || s !== es || b !== eb)
                $display("FAIL seamless_result_%0d: got %h/%0d want 40/4", r, s, b);
            else passed++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int w;
        logic [SUM_W-1:0] s, es;
        logic [CNT_W-1:0] b, eb;
        bit ok;
        bus.out_ready = 1'b1;
        drive_beat(32'd9, 1'b0, w);
        drive_beat(32'd11, 1'b0, w);
        resetn = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL midreset_state: got v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); else passed++;
        @(negedge clk);
        for (int i = 0; i < BEATS; i++) drive_beat(32'd5, 1'b0, w);
        pop_result(s, b, ok);
        pop_exp(es, eb);
        checks++;
        if (!ok || s !== SUM_W'(20) || b !== CNT_W'(4) || s !== es || b !== eb)
            $display("FAIL midreset_result: got %0d/%0d want 20/4", s, b);
        else passed++;
        repeat (3) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) $display("FAIL midreset_extra: got %0d extra results want 0", obs_q.size()); else passed++;
        // Reset while a result is pending discards it.
        bus.out_ready = 1'b0;
        for (int i = 0; i < BEATS; i++) drive_beat(WIDTH'($urandom), 1'b0, w);
        resetn = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_beats !== '0) $display("FAIL emit_reset: got v=%b n=%0d want 0/0", bus.out_valid, bus.out_beats); else passed++;
        bus.out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_max();
        int w;
        logic [SUM_W-1:0] s, es;
        logic [CNT_W-1:0] b, eb;
        bit ok;
        bus.out_ready = 1'b1;
        for (int i = 0; i < BEATS; i++) drive_beat(32'hFFFF_FFFF, 1'b0, w);
        pop_result(s, b, ok);
        pop_exp(es, eb);
        checks++;
        if (!ok || s !== 34'h3_FFFF_FFFC || b !== CNT_W'(4) || s !== es || b !== eb)
            $display("FAIL max_sum: got %h/%0d want 3fffffffc/4", s, b);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_random();
        int w, n;
        logic [SUM_W-1:0] s, es;
        logic [CNT_W-1:0] b, eb;
        bit ok;
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) drive_beat(WIDTH'($urandom), ($urandom_range(0, 3) == 0), w);
        drive_beat(WIDTH'($urandom), 1'b1, w);
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n = 0;
        while (exp_q.size() > 0) begin
            pop_result(s, b, ok);
            pop_exp(es, eb);
            checks++;
            if (!ok || s !== es || b !== eb) $display("FAIL random_result_%0d: got %h/%0d want %h/%0d", n, s, b, es, eb); else passed++;
            n++;
            if (!ok) break;
        end
        checks++;
        if (obs_q.size() != 0) $display("FAIL random_extra: got %0d unmatched results want 0", obs_q.size()); else passed++;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_full_frame();
        test_early_end();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_max();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/stream_beat_accumulator.md
# stream_beat_accumulator

Downstream consumer of the single-stage pipeline register. Accepts WIDTH-bit beats over valid/ready, sums up to BEATS consecutive beats (or fewer if a frame ends early on in_last), and presents the frame sum and beat count on a registered valid/ready output. Full throughput: a new frame may start in the same cycle the previous result is taken.

## Interface
- WIDTH, 32, input beat width
- BEATS, 4, maximum beats per frame (≥1)
- SUM_W, WIDTH+$clog2(BEATS) (min WIDTH+1), output sum width; derived, not overridden
- CNT_W, $clog2(BEATS+1), beat-count width; derived

Reset scheme: one clock; reset is synchronous and active-high.
- clk  input  1  sole clock, rising edge
- resetn  input  1  synchronous reset, active-high; the port keeps the codebase's reset name
- in_valid  input  1  upstream beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_data  input  WIDTH  beat payload, unsigned
- in_last  input  1  beat closes the frame early; qualified by in_valid
- out_valid  output  1  frame result valid
- out_ready  input  1  downstream accepts result
- out_data  output  SUM_W  unsigned frame sum
- out_beats  output  CNT_W  beats in the frame, 1..BEATS

## Operation
- States: ACCUM (collecting), EMIT (result held). Reset → ACCUM, sum=0, cnt=0.
- Beat accepted when in_valid && in_ready.
- in_ready = !resetn_active && (state==ACCUM || out_ready).
- ACCUM, accept: if cnt==BEATS-1 or in_last → result = sum+in_data, out_beats = cnt+1, sum=0, cnt=0, go EMIT. Else sum += in_data, cnt++.
- ACCUM, no accept: hold.
- EMIT: out_valid=1; out_data/out_beats stable until out_valid && out_ready.
- EMIT, out_ready without accept: go ACCUM, sum=0, cnt=0.
- EMIT, out_ready with accept: the beat starts the next frame (sum=in_data, cnt=1). If BEATS==1 or in_last, load the new result and stay in EMIT.
- EMIT, !out_ready: in_ready=0 and no beat is taken.
- Arithmetic: zero-extend in_data to SUM_W; SUM_W guarantees no overflow (BEATS×(2^WIDTH−1) fits).
- in_last on the BEATS-th beat: same as a full frame; the count is not doubled.

## Timing
- Reset values: out_valid=0, out_data=0, out_beats=0. in_ready=0 while resetn is high, 1 on the first cycle after release.
- Latency: out_valid rises on the cycle after the closing beat's handshake.
- Throughput: one beat per cycle sustained, including across frame boundaries when out_ready=1.
- Reset mid-frame or in EMIT discards partial sum and pending result; out_valid=0 on the next cycle.
- out_valid never drops without an out_ready handshake, except on reset.
- in_ready depends combinationally on out_ready only; no comb path from in_valid to in_ready.

## Structure
- Package stream_acc_pkg: state enum (ACCUM, EMIT), width function for SUM_W/CNT_W.
- No sub-module. Counter, accumulator and result register are inline. Output registers drive out_* directly.

## Test plan
- Full frame: beats 1,2,3,4 back-to-back, out_ready=1 → out_data=10, out_beats=4, out_valid one cycle after beat 4.
- Early end: beats 0xFFFF_FFFF, 0x1 with in_last on the 2nd → out_data=0x1_0000_0000, out_beats=2.
- Backpressure: frame completes with out_ready=0 for 3 cycles → in_ready=0, out_data stable, next beat not taken. When out_ready=1, handshake completes and in_ready goes high.
- Seamless: 3 full frames of 0x10 beats with out_ready=1 → 3 results of 0x40, with no idle cycle between input beats.
- Reset mid-frame: 2 beats, resetn high 1 cycle, then 4 beats of 5 → single result 20 (beats=4); partial sum discarded.
- Max overflow: 4 beats of 0xFFFF_FFFF → out_data=0x3_FFFF_FFFC (SUM_W=34).
